// File: rtl/timer_disp_pkg.sv
// rtl/timer_disp_pkg.sv - scan FSM states and active-high 7-segment code table
// Shared by seg7_decoder and seg7_scan_drv in the hw_timer display path.
package timer_disp_pkg;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } scan_state_t;

   // Index = digit value; bit order {g,f,e,d,c,b,a}; hex A,b,C,d,E,F above 9
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational 4-bit digit to active-high 7-segment code
// Polarity and leading-zero blanking are applied by the caller.
module seg7_decoder
   import timer_disp_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/seg7_scan_drv.sv
// rtl/seg7_scan_drv.sv - shadow/display digit banks and blanked 7-segment scan driver
// Optional leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_drv
   import timer_disp_pkg::*;
#(
   parameter int DEC_DIGITS    = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter int BLANK_CYCLES  = 500,
   parameter int ANODE_ACT_LOW = 1,
   parameter int SEG_ACT_LOW   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            digit_i,
   input  logic [DEC_DIGITS-1:0] digit_we_i,
   output logic [6:0]            seg_o,
   output logic [DEC_DIGITS-1:0] an_o,
   output logic                  frame_done_o
);

   localparam int IW   = (DEC_DIGITS > 1) ? $clog2(DEC_DIGITS) : 1;
   localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [DEC_DIGITS-1:0] AN_OFF  = (ANODE_ACT_LOW != 0) ? {DEC_DIGITS{1'b1}}
                                                                    : {DEC_DIGITS{1'b0}};
   localparam logic [6:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

   scan_state_t                  state, state_nx;
   logic [CW-1:0]                cnt, cnt_nx;
   logic [IW-1:0]                idx, idx_nx;
   logic [DEC_DIGITS-1:0]        an_nx;
   logic [6:0]                   seg_nx;
   logic [DEC_DIGITS-1:0][3:0]   shadow, shadow_nx, display;
   logic [6:0]                   seg_code;
   logic [6:0]                   drive_seg;
   logic [DEC_DIGITS-1:0]        one_hot;
   logic                         lz_blank;

   // Shadow bank with this cycle's writes folded in; a top-slot write commits it whole
   always_comb begin
      shadow_nx = shadow;
      for (int k = 0; k < DEC_DIGITS; k++) begin
         if (digit_we_i[k]) shadow_nx[k] = digit_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow       <= '0;
         display      <= '0;
         frame_done_o <= 1'b0;
      end else begin
         shadow       <= shadow_nx;
         frame_done_o <= digit_we_i[DEC_DIGITS-1];
         if (digit_we_i[DEC_DIGITS-1]) display <= shadow_nx;
      end
   end

   seg7_decoder u_dec (
      .digit (display[idx]),
      .seg   (seg_code)
   );

`ifdef SEG7_LZ_BLANK_EN
   always_comb begin
      lz_blank = (idx != '0);
      for (int j = 0; j < DEC_DIGITS; j++) begin
         if (j >= int'(idx) && display[j] != 4'd0) lz_blank = 1'b0;
      end
   end
`else
   assign lz_blank = 1'b0;
`endif

   assign drive_seg = lz_blank ? SEG_OFF : ((SEG_ACT_LOW != 0) ? ~seg_code : seg_code);

   always_comb begin
      one_hot      = '0;
      one_hot[idx] = 1'b1;
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      idx_nx   = idx;
      an_nx    = an_o;
      seg_nx   = seg_o;
      case (state)
         S_BLANK: begin
            if (cnt == CW'(BLANK_CYCLES - 1)) begin
               state_nx = S_DRIVE;
               cnt_nx   = '0;
               an_nx    = (ANODE_ACT_LOW != 0) ? ~one_hot : one_hot;
               seg_nx   = drive_seg;
            end
         end
         S_DRIVE: begin
            if (cnt == CW'(REFRESH_DIV - 1)) begin
               state_nx = S_BLANK;
               cnt_nx   = '0;
               idx_nx   = (idx == IW'(DEC_DIGITS - 1)) ? '0 : idx + 1'b1;
               an_nx    = AN_OFF;
               seg_nx   = SEG_OFF;
            end
         end
         default: begin
            state_nx = S_BLANK;
            cnt_nx   = '0;
            an_nx    = AN_OFF;
            seg_nx   = SEG_OFF;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_BLANK;
         cnt   <= '0;
         idx   <= '0;
         an_o  <= AN_OFF;
         seg_o <= SEG_OFF;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         idx   <= idx_nx;
         an_o  <= an_nx;
         seg_o <= seg_nx;
      end
   end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb/tb_seg7_scan_drv.sv - randomized self-checking bench for seg7_scan_drv
// Reference model derives the scan position from the edge count since reset release.
module tb_seg7_scan_drv;

   localparam int RD  = 4;
   localparam int BC  = 1;
   localparam int ND  = 4;
   localparam int PER = RD + BC;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    digit_i = '0;
   logic [ND-1:0] digit_we_i = '0;
   logic [6:0]    seg_o;
   logic [ND-1:0] an_o;
   logic          frame_done_o;

   always #5 clk = ~clk;

   seg7_scan_drv #(
      .DEC_DIGITS    (ND),
      .REFRESH_DIV   (RD),
      .BLANK_CYCLES  (BC),
      .ANODE_ACT_LOW (1),
      .SEG_ACT_LOW   (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .digit_i      (digit_i),
      .digit_we_i   (digit_we_i),
      .seg_o        (seg_o),
      .an_o         (an_o),
      .frame_done_o (frame_done_o)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int         n;
   logic [3:0] sh_m [ND];
   logic [3:0] dp_m [ND];
   logic [6:0] lat_m;
   logic       fd_m;
   logic [11:0] got, exp_v;

   function automatic logic [6:0] ref_code(int s);
      logic [6:0] c;
      c = tab[dp_m[s]];
`ifdef SEG7_LZ_BLANK_EN
      if (s > 0) begin
         bit z = 1'b1;
         for (int j = s; j < ND; j++) if (dp_m[j] != 4'd0) z = 1'b0;
         if (z) c = 7'h00;
      end
`endif
      return c;
   endfunction

   function automatic logic [11:0] ref_out();
      logic [3:0] an;
      logic [6:0] sg;
      if (n >= BC && ((n - BC) % PER) < RD) begin
         an = ~(4'b0001 << (((n - BC) / PER) % ND));
         sg = ~lat_m;
      end else begin
         an = 4'hF;
         sg = 7'h7F;
      end
      return {an, sg, fd_m};
   endfunction

   function automatic bit enters_slot(int edge_no, int slot);
      return edge_no >= BC && ((edge_no - BC) % PER) == 0 && (((edge_no - BC) / PER) % ND) == slot;
   endfunction

   task automatic model_reset();
      n = 0;
      for (int k = 0; k < ND; k++) begin
         sh_m[k] = 4'd0;
         dp_m[k] = 4'd0;
      end
      lat_m = 7'h00;
      fd_m  = 1'b0;
   endtask

   // Apply one cycle of inputs, advance the model across the edge, sample 1 unit later
   task automatic step(input logic [3:0] we, input logic [3:0] d);
      digit_we_i = we;
      digit_i    = d;
      @(posedge clk);
      n++;
      if (n >= BC && ((n - BC) % PER) == 0) lat_m = ref_code(((n - BC) / PER) % ND);
      for (int k = 0; k < ND; k++) if (we[k]) sh_m[k] = d;
      if (we[ND-1]) dp_m = sh_m;
      fd_m = we[ND-1];
      #1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      vectors++;
      if ({an_o, seg_o, frame_done_o} !== {4'hF, 7'h7F, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_initial got an=%h seg=%h fd=%b want an=F seg=7F fd=0", an_o, seg_o, frame_done_o);
      end
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 7; i++) step(4'($urandom_range(0, 7)), 4'($urandom));
      step(4'b1000, 4'($urandom));
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({an_o, seg_o, frame_done_o} !== {4'hF, 7'h7F, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_async got an=%h seg=%h fd=%b want an=F seg=7F fd=0", an_o, seg_o, frame_done_o);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
      vectors++;
      if ({an_o, seg_o, frame_done_o} !== {4'hF, 7'h7F, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_release got an=%h seg=%h fd=%b want an=F seg=7F fd=0", an_o, seg_o, frame_done_o);
      end
      step(4'b0000, 4'd0);
      vectors++;
      if (an_o !== 4'hE || seg_o !== ~tab[0]) begin
         miscompares++;
         $display("FAIL reset_first_drive got an=%h seg=%h want an=E seg=%h", an_o, seg_o, ~tab[0]);
      end
   endtask

   task automatic test_frame_write();
      int  pulses = 0;
      bit  saw3 = 1'b0, saw0 = 1'b0;
      step(4'b0001, 4'd4);
      pulses += int'(frame_done_o);
      step(4'b0010, 4'd3);
      pulses += int'(frame_done_o);
      step(4'b0100, 4'd2);
      pulses += int'(frame_done_o);
      step(4'b1000, 4'd1);
      for (int i = 0; i < 30; i++) begin
         pulses += int'(frame_done_o);
         got = {an_o, seg_o, frame_done_o};
         exp_v = ref_out();
         vectors++;
         if (got !== exp_v) begin
            miscompares++;
            $display("FAIL frame_write n=%0d got %h want %h", n, got, exp_v);
         end
         if (i > 0 && an_o == 4'h7 && seg_o == ~7'h06) saw3 = 1'b1;
         if (i > 5 && an_o == 4'hE && seg_o == ~7'h66) saw0 = 1'b1;
         step(4'b0000, 4'($urandom));
      end
      vectors++;
      if (pulses != 1 || !saw3 || !saw0) begin
         miscompares++;
         $display("FAIL frame_write_summary got pulses=%0d saw3=%b saw0=%b want 1 1 1", pulses, saw3, saw0);
      end
   endtask

   task automatic test_timing();
      logic [3:0] seq [48];
      int first = -1;
      for (int i = 0; i < 48; i++) begin
         step(4'b0000, 4'd0);
         seq[i] = an_o;
         exp_v = ref_out();
         vectors++;
         if (an_o !== exp_v[11:8]) begin
            miscompares++;
            $display("FAIL timing_an n=%0d got %h want %h", n, an_o, exp_v[11:8]);
         end
      end
      for (int i = 1; i < 24; i++) if (first < 0 && seq[i] == 4'hE && seq[i-1] == 4'hF) first = i;
      vectors++;
      if (first < 0 ||
          {seq[first+3], seq[first+4], seq[first+5], seq[first+9], seq[first+10],
           seq[first+14], seq[first+15], seq[first+19], seq[first+20]} !==
          {4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF, 4'hE}) begin
         miscompares++;
         $display("FAIL timing_sequence start=%0d got an pattern mismatch, want E..F D..F B..F 7..F E", first);
      end
   endtask

   task automatic test_partial_frame();
      int pulses = 0;
      step(4'b0001, 4'($urandom));
      step(4'b0010, 4'($urandom));
      step(4'b0100, 4'($urandom));
      for (int i = 0; i < 22; i++) begin
         pulses += int'(frame_done_o);
         got = {an_o, seg_o, frame_done_o};
         exp_v = ref_out();
         vectors++;
         if (got !== exp_v) begin
            miscompares++;
            $display("FAIL partial_hidden n=%0d got %h want %h", n, got, exp_v);
         end
         step(4'b0000, 4'd0);
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++;
         $display("FAIL partial_no_done got pulses=%0d want 0", pulses);
      end
      step(4'b1000, 4'($urandom));
      vectors++;
      if (frame_done_o !== 1'b1) begin
         miscompares++;
         $display("FAIL partial_commit_done got %b want 1", frame_done_o);
      end
      for (int i = 0; i < 22; i++) begin
         step(4'b0000, 4'd0);
         got = {an_o, seg_o, frame_done_o};
         exp_v = ref_out();
         vectors++;
         if (got !== exp_v) begin
            miscompares++;
            $display("FAIL partial_commit n=%0d got %h want %h", n, got, exp_v);
         end
      end
   endtask

   task automatic test_commit_in_drive();
      logic [6:0] held;
      logic [3:0] v;
      int guard = 0;
      while (!enters_slot(n + 1, 1) && guard < 40) begin
         step(4'b0000, 4'd0);
         guard++;
      end
      step(4'b0000, 4'd0);
      held = seg_o;
      v = (dp_m[2] == 4'hF) ? 4'h1 : dp_m[2] + 4'h1;
      step(4'b1111, v);
      for (int i = 0; i < 8; i++) begin
         got = {an_o, seg_o, frame_done_o};
         exp_v = ref_out();
         vectors++;
         if (got !== exp_v) begin
            miscompares++;
            $display("FAIL commit_drive n=%0d got %h want %h", n, got, exp_v);
         end
         vectors++;
         if ((an_o == 4'hD && seg_o !== held) || (an_o == 4'hB && seg_o !== ~tab[v])) begin
            miscompares++;
            $display("FAIL commit_drive_hold an=%h got seg=%h want held=%h new=%h", an_o, seg_o, held, ~tab[v]);
         end
         step(4'b0000, 4'd0);
      end
   endtask

   task automatic test_lz_frame();
      logic [6:0] want;
      step(4'b0001, 4'd0);
      step(4'b0010, 4'd7);
      step(4'b0100, 4'd0);
      step(4'b1000, 4'd0);
      for (int i = 0; i < 26; i++) begin
         step(4'b0000, 4'd0);
         got = {an_o, seg_o, frame_done_o};
         exp_v = ref_out();
         vectors++;
         if (got !== exp_v) begin
            miscompares++;
            $display("FAIL lz_model n=%0d got %h want %h", n, got, exp_v);
         end
         if (i >= 5 && an_o != 4'hF) begin
            case (an_o)
`ifdef SEG7_LZ_BLANK_EN
               4'h7, 4'hB: want = 7'h7F;
`else
               4'h7, 4'hB: want = ~7'h3F;
`endif
               4'hD:    want = ~7'h07;
               default: want = ~7'h3F;
            endcase
            vectors++;
            if (seg_o !== want) begin
               miscompares++;
               $display("FAIL lz_digit an=%h got seg=%h want %h", an_o, seg_o, want);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] we;
      int r;
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         we = (r < 4) ? 4'(1 << r) : (r < 6) ? 4'($urandom) : 4'b0000;
         step(we, 4'($urandom));
         got = {an_o, seg_o, frame_done_o};
         exp_v = ref_out();
         vectors++;
         if (got !== exp_v) begin
            miscompares++;
            $display("FAIL random n=%0d got %h want %h", n, got, exp_v);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_frame_write();
      test_timing();
      test_partial_frame();
      test_commit_in_drive();
      test_lz_frame();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
